// File: rtl/fft32_out_serializer_if.sv
// Frame-in / beat-out bus of fft32_out_serializer. The master modport is the serializer side.
// The out_mag signal exists only when FFT32_SER_MAG_EN is defined.
interface fft32_out_serializer_if #(
  parameter int NBINS = 32,
  parameter int DW    = 11
);
  logic                          in_valid;
  logic signed [DW-1:0]          in_real [NBINS];
  logic signed [DW-1:0]          in_imag [NBINS];
  logic                          out_valid;
  logic                          out_ready;
  logic signed [DW-1:0]          out_real;
  logic signed [DW-1:0]          out_imag;
  logic [$clog2(NBINS)-1:0]      out_index;
  logic                          out_last;
`ifdef FFT32_SER_MAG_EN
  logic [2*DW-1:0]               out_mag;
`endif

  modport master (
    input  in_valid, in_real, in_imag, out_ready,
`ifdef FFT32_SER_MAG_EN
    output out_mag,
`endif
    output out_valid, out_real, out_imag, out_index, out_last
  );

  modport slave (
    output in_valid, in_real, in_imag, out_ready,
`ifdef FFT32_SER_MAG_EN
    input  out_mag,
`endif
    input  out_valid, out_real, out_imag, out_index, out_last
  );
endinterface

// File: rtl/fft32_out_serializer.sv
// Ping-pong buffer that captures parallel 32-bin FFT frames and streams them one bin per beat.
// Define FFT32_SER_MAG_EN to add the out_mag (re^2 + im^2) output.
module fft32_out_serializer #(
  parameter int NBINS = 32,
  parameter int DW    = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fft32_out_serializer_if.master bus,
  output logic                   overflow
);
  localparam int            IW       = $clog2(NBINS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBINS - 1);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} fill_e;

  fill_e                state_r, state_s;
  logic                 wbank_r, rbank_r, rbank_s;
  logic [IW-1:0]        idx_r, idx_s;
  logic                 overflow_r;
  logic                 xfer_s, last_s, accept_s, drop_s, fwd_s, valid_s, last_beat_s;
  logic                 out_valid_r, out_last_r;
  logic signed [DW-1:0] real_s, imag_s, out_real_r, out_imag_r;
  logic signed [DW-1:0] bank_re [2][NBINS];
  logic signed [DW-1:0] bank_im [2][NBINS];

  // Handshake decode: a frame may land in a full buffer only if a bank frees this very cycle
  always_comb begin
    xfer_s   = out_valid_r && bus.out_ready;
    last_s   = xfer_s && (idx_r == LAST_IDX);
    accept_s = bus.in_valid && ((state_r != FULL) || last_s);
    drop_s   = bus.in_valid && !accept_s;
  end

  // Next fill state
  always_comb begin
    state_s = state_r;
    case (state_r)
      EMPTY: if (accept_s) state_s = ONE; else state_s = EMPTY;
      ONE: begin
        if (accept_s && !last_s)      state_s = FULL;
        else if (!accept_s && last_s) state_s = EMPTY;
        else                          state_s = ONE;
      end
      FULL: if (last_s && !accept_s) state_s = ONE; else state_s = FULL;
      default: state_s = EMPTY;
    endcase
  end

  // Next-beat outputs; bypass the incoming frame when it lands in the bank read next
  always_comb begin
    if (last_s)      idx_s = '0;
    else if (xfer_s) idx_s = idx_r + IW'(1);
    else             idx_s = idx_r;
    rbank_s = rbank_r ^ last_s;
    valid_s = (state_s != EMPTY);
    fwd_s   = accept_s && (wbank_r == rbank_s);
    if (!valid_s) begin
      real_s = '0;
      imag_s = '0;
    end else if (fwd_s) begin
      real_s = bus.in_real[idx_s];
      imag_s = bus.in_imag[idx_s];
    end else begin
      real_s = bank_re[rbank_s][idx_s];
      imag_s = bank_im[rbank_s][idx_s];
    end
    last_beat_s = valid_s && (idx_s == LAST_IDX);
  end

  // Control state and registered beat outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      idx_r       <= '0;
      wbank_r     <= 1'b0;
      rbank_r     <= 1'b0;
      overflow_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_real_r  <= '0;
      out_imag_r  <= '0;
    end else begin
      state_r     <= state_s;
      idx_r       <= idx_s;
      wbank_r     <= wbank_r ^ accept_s;
      rbank_r     <= rbank_s;
      overflow_r  <= overflow_r | drop_s;
      out_valid_r <= valid_s;
      out_last_r  <= last_beat_s;
      out_real_r  <= real_s;
      out_imag_r  <= imag_s;
    end
  end

  // Frame capture into the write bank
  always_ff @(posedge clk) begin
    if (accept_s) begin
      for (int k = 0; k < NBINS; k++) begin
        bank_re[wbank_r][k] <= bus.in_real[k];
        bank_im[wbank_r][k] <= bus.in_imag[k];
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_real  = out_real_r;
  assign bus.out_imag  = out_imag_r;
  assign bus.out_index = idx_r;
  assign bus.out_last  = out_last_r;
  assign overflow      = overflow_r;

`ifdef FFT32_SER_MAG_EN
  function automatic logic [2*DW-1:0] mag_sq(input logic signed [DW-1:0] re,
                                             input logic signed [DW-1:0] im);
    logic signed [2*DW-1:0] re2, im2;
    re2 = (2*DW)'(re) * (2*DW)'(re);
    im2 = (2*DW)'(im) * (2*DW)'(im);
    return $unsigned(re2) + $unsigned(im2);
  endfunction

  // Zero outputs when idle make the magnitude zero without extra gating
  assign bus.out_mag = mag_sq(out_real_r, out_imag_r);
`endif
endmodule

// File: tb/tb_fft32_out_serializer.sv
// Directed + random bench for fft32_out_serializer against a queue-of-beats reference model.
module tb_fft32_out_serializer;
  localparam int NB = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic overflow;

  fft32_out_serializer_if #(.NBINS(32), .DW(11)) bus ();
  fft32_out_serializer #(.NBINS(32), .DW(11)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int          n_assert  = 0;
  int          n_fail    = 0;
  int          dut_beats = 0;
  logic [21:0] q [$];
  logic        ovf_m = 1'b0;
  logic [10:0] fr_re [NB];
  logic [10:0] fr_im [NB];
  int          bp_pat [4] = '{1, 0, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put_bin(input int k, input logic [10:0] re, input logic [10:0] im);
    fr_re[k] = re;
    fr_im[k] = im;
    bus.in_real[k] = re;
    bus.in_imag[k] = im;
  endtask

  task automatic frame_rand();
    for (int k = 0; k < NB; k++) put_bin(k, 11'($urandom), 11'($urandom));
  endtask

  task automatic frame_const(input int v);
    for (int k = 0; k < NB; k++) put_bin(k, 11'(v), 11'($urandom));
  endtask

  task automatic frame_ramp();
    for (int k = 0; k < NB; k++) put_bin(k, 11'(k), 11'(-k));
  endtask

  // Expected outputs: head of the beat queue; index follows from how much of its frame is left
  task automatic check_outputs(input string ph);
    int          sz;
    logic [21:0] h;
    logic [4:0]  ei;
    int          mr, mi;
    sz = q.size();
    h  = (sz != 0) ? q[0] : 22'd0;
    ei = 5'((NB - (sz % NB)) % NB);
    chk({ph, "_valid"}, 32'(bus.out_valid), 32'(sz != 0));
    chk({ph, "_real"},  32'($unsigned(bus.out_real)), 32'(h[21:11]));
    chk({ph, "_imag"},  32'($unsigned(bus.out_imag)), 32'(h[10:0]));
    chk({ph, "_index"}, 32'(bus.out_index), 32'(ei));
    chk({ph, "_last"},  32'(bus.out_last), 32'(sz % NB == 1));
    chk({ph, "_ovf"},   32'(overflow), 32'(ovf_m));
    mr = int'($signed(h[21:11]));
    mi = int'($signed(h[10:0]));
`ifdef FFT32_SER_MAG_EN
    chk({ph, "_mag"}, 32'(bus.out_mag), 32'(mr * mr + mi * mi));
`else
    if (mr == mi + 1) dut_beats = dut_beats + 0;
`endif
  endtask

  // Model of one clock edge: pop on transfer, capture if a bank is (or becomes) free
  task automatic model_edge(input logic iv, input logic rdy);
    logic xfer, lst, acc;
    int   frames;
    frames = (q.size() + NB - 1) / NB;
    xfer   = (q.size() != 0) && rdy;
    lst    = xfer && (q.size() % NB == 1);
    acc    = iv && ((frames < 2) || lst);
    if (xfer) void'(q.pop_front());
    if (acc) for (int k = 0; k < NB; k++) q.push_back({fr_re[k], fr_im[k]});
    if (iv && !acc) ovf_m = 1'b1;
  endtask

  task automatic cycle(input logic iv, input logic rdy, input string ph);
    bus.in_valid  = iv;
    bus.out_ready = rdy;
    check_outputs(ph);
    if (bus.out_valid && rdy) dut_beats++;
    if (rst_n) model_edge(iv, rdy);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int guard;
    // Reset held with random traffic
    frame_rand();
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    repeat (4) begin
      frame_rand();
      cycle(1'b1, 1'($urandom_range(0, 1)), "rst");
    end
    rst_n = 1'b1;
    repeat (3) cycle(1'b0, 1'b1, "post_rst");

    // Single ramp frame
    frame_ramp();
    cycle(1'b1, 1'b1, "single");
    repeat (34) cycle(1'b0, 1'b1, "single");

    // Backpressure 1,0,0,1,...
    frame_ramp();
    cycle(1'b1, 1'b1, "bp");
    for (int i = 0; i < 140; i++) cycle(1'b0, 1'(bp_pat[i % 4]), "bp");

    // Burst of three frames on consecutive cycles; the third is dropped
    frame_const(1);
    cycle(1'b1, 1'b1, "burst");
    frame_const(2);
    cycle(1'b1, 1'b1, "burst");
    frame_const(3);
    cycle(1'b1, 1'b1, "burst");
    repeat (70) cycle(1'b0, 1'b1, "burst");
    chk("burst_ovf_sticky", 32'(overflow), 32'd1);

    // Asynchronous reset mid-stream at index 10
    frame_rand();
    cycle(1'b1, 1'b1, "mid");
    repeat (10) cycle(1'b0, 1'b1, "mid");
    chk("mid_index10", 32'(bus.out_index), 32'd10);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_ovf", 32'(overflow), 32'd0);
    q.delete();
    ovf_m = 1'b0;
    repeat (2) cycle(1'b0, 1'b1, "mid_rst");
    rst_n = 1'b1;
    frame_ramp();
    cycle(1'b1, 1'b1, "mid_after");
    repeat (34) cycle(1'b0, 1'b1, "mid_after");

    // Third frame strobed exactly on the last beat of a full buffer
    dut_beats = 0;
    frame_rand();
    cycle(1'b1, 1'b1, "bnd");
    frame_rand();
    cycle(1'b1, 1'b1, "bnd");
    guard = 0;
    while (q.size() != NB + 1 && guard < 100) begin
      cycle(1'b0, 1'b1, "bnd");
      guard++;
    end
    chk("bnd_reach_last", 32'(bus.out_last), 32'd1);
    frame_rand();
    cycle(1'b1, 1'b1, "bnd_last");
    repeat (70) cycle(1'b0, 1'b1, "bnd");
    chk("bnd_beats", 32'(dut_beats), 32'd96);
    chk("bnd_ovf", 32'(overflow), 32'd0);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic iv;
      iv = ($urandom_range(0, 11) == 0);
      if (iv) frame_rand();
      cycle(iv, 1'($urandom_range(0, 3) != 0), "rand");
    end
    repeat (100) cycle(1'b0, 1'b1, "rand_drain");

    // Magnitude extremes
    frame_rand();
    put_bin(0, 11'h400, 11'h400);
    put_bin(1, 11'd3, 11'h7FC);
    cycle(1'b1, 1'b1, "mag");
`ifdef FFT32_SER_MAG_EN
    chk("mag_max", 32'(bus.out_mag), 32'h0020_0000);
`endif
    cycle(1'b0, 1'b1, "mag");
`ifdef FFT32_SER_MAG_EN
    chk("mag_3_4", 32'(bus.out_mag), 32'd25);
`endif
    repeat (34) cycle(1'b0, 1'b1, "mag");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
